// File: rtl/campos_para_segundos.sv
// campos_para_segundos
//   Composes a calendar-style duration (years, months, days, hours, minutes,
//   seconds) into a 32-bit count of seconds. One field is weighted and added
//   per clock under a start/busy/done handshake. Fields are range-checked when
//   the request is accepted, and the sum saturates on 32-bit overflow.
//
// Ports
//   clk        : clock, all logic on the rising edge
//   rst_n      : synchronous active-low reset
//   inicio     : start request, honoured only while idle
//   anos       : years (bounded only by overflow)
//   mes        : months  0..11
//   dias       : days    0..29
//   horas      : hours   0..23
//   minutos    : minutes 0..59
//   segundos   : seconds 0..59
//   total_seg  : composed seconds, held until the next completion
//   ocupado    : conversion in progress
//   pronto     : one-cycle pulse, total_seg and flags valid
//   erro_faixa : a field was out of range (total_seg forced to 0)
//   estouro    : the true sum exceeded 2^32-1 (total_seg saturated)
module campos_para_segundos #(
  parameter logic [31:0] SEG_ANO = 32'd31536000,
  parameter logic [31:0] SEG_MES = 32'd2592000,
  parameter logic [31:0] SEG_DIA = 32'd86400
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inicio,
  input  logic [31:0] anos,
  input  logic [31:0] mes,
  input  logic [31:0] dias,
  input  logic [31:0] horas,
  input  logic [31:0] minutos,
  input  logic [31:0] segundos,
  output logic [31:0] total_seg,
  output logic        ocupado,
  output logic        pronto,
  output logic        erro_faixa,
  output logic        estouro
);

  typedef enum logic [2:0] {
    IDLE, ANOS, MES, DIAS, HORAS, MIN, SEG, ERRO
  } estado_t;

  estado_t     estado, estado_n;

  // Fields captured at acceptance so the inputs may change mid-conversion.
  logic [31:0] anos_r, mes_r, dias_r, horas_r, min_r, seg_r;

  logic [31:0] acc;
  logic        ovf;

  logic [31:0] fator, peso;
  logic [63:0] produto;
  logic [32:0] soma;
  logic        ovf_fim;
  logic        fora_faixa;

  function automatic logic [31:0] satura(input logic [31:0] v, input logic o);
    return o ? 32'hFFFF_FFFF : v;
  endfunction

  // Selects the field and weight for the current accumulation step.
  always_comb begin
    fator = '0;
    peso  = '0;
    case (estado)
      ANOS:    begin fator = anos_r;  peso = SEG_ANO;    end
      MES:     begin fator = mes_r;   peso = SEG_MES;    end
      DIAS:    begin fator = dias_r;  peso = SEG_DIA;    end
      HORAS:   begin fator = horas_r; peso = 32'd3600;   end
      MIN:     begin fator = min_r;   peso = 32'd60;     end
      SEG:     begin fator = seg_r;   peso = 32'd1;      end
      default: begin fator = '0;      peso = '0;         end
    endcase
  end

  // Product at full 64 bits and sum at 33 bits; any spill beyond bit 31
  // makes the overflow sticky for the rest of the conversion.
  always_comb begin
    produto = {32'd0, fator} * {32'd0, peso};
    soma    = {1'b0, acc} + {1'b0, produto[31:0]};
    ovf_fim = ovf | (|produto[63:32]) | soma[32];
  end

  always_comb begin
    fora_faixa = (mes > 32'd11) || (dias > 32'd29) || (horas > 32'd23) ||
                 (minutos > 32'd59) || (segundos > 32'd59);
  end

  always_comb begin
    estado_n = estado;
    case (estado)
      IDLE:    if (inicio) estado_n = fora_faixa ? ERRO : ANOS;
      ANOS:    estado_n = MES;
      MES:     estado_n = DIAS;
      DIAS:    estado_n = HORAS;
      HORAS:   estado_n = MIN;
      MIN:     estado_n = SEG;
      SEG:     estado_n = IDLE;
      ERRO:    estado_n = IDLE;
      default: estado_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) estado <= IDLE;
    else        estado <= estado_n;
  end

  always_ff @(posedge clk) begin
    if (estado == IDLE && inicio) begin
      anos_r  <= anos;
      mes_r   <= mes;
      dias_r  <= dias;
      horas_r <= horas;
      min_r   <= minutos;
      seg_r   <= segundos;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc        <= '0;
      ovf        <= 1'b0;
      total_seg  <= '0;
      ocupado    <= 1'b0;
      pronto     <= 1'b0;
      erro_faixa <= 1'b0;
      estouro    <= 1'b0;
    end else begin
      pronto <= 1'b0;
      case (estado)
        IDLE: begin
          if (inicio) begin
            acc        <= '0;
            ovf        <= 1'b0;
            ocupado    <= 1'b1;
            erro_faixa <= 1'b0;
            estouro    <= 1'b0;
          end
        end
        ANOS, MES, DIAS, HORAS, MIN: begin
          acc <= soma[31:0];
          ovf <= ovf_fim;
        end
        SEG: begin
          acc        <= soma[31:0];
          ovf        <= ovf_fim;
          total_seg  <= satura(soma[31:0], ovf_fim);
          estouro    <= ovf_fim;
          erro_faixa <= 1'b0;
          pronto     <= 1'b1;
          ocupado    <= 1'b0;
        end
        ERRO: begin
          total_seg  <= '0;
          erro_faixa <= 1'b1;
          estouro    <= 1'b0;
          pronto     <= 1'b1;
          ocupado    <= 1'b0;
        end
        default: ocupado <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_campos_para_segundos.sv
module tb_campos_para_segundos;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        inicio;
  logic [31:0] anos, mes, dias, horas, minutos, segundos;
  logic [31:0] total_seg;
  logic        ocupado, pronto, erro_faixa, estouro;

  campos_para_segundos dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .inicio     (inicio),
    .anos       (anos),
    .mes        (mes),
    .dias       (dias),
    .horas      (horas),
    .minutos    (minutos),
    .segundos   (segundos),
    .total_seg  (total_seg),
    .ocupado    (ocupado),
    .pronto     (pronto),
    .erro_faixa (erro_faixa),
    .estouro    (estouro)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] total;
    logic        erro;
    logic        est;
    int          lat;
    int          aceito;
  } esp_t;

  esp_t fila[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   cyc    = 0;
  int   rem    = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)", tag, got, got, exp, exp);
  endtask

  function automatic esp_t modelo(input logic [31:0] a, m, d, h, mi, s, input int c);
    esp_t        e;
    logic [63:0] t;
    e.aceito = c;
    if (m > 11 || d > 29 || h > 23 || mi > 59 || s > 59) begin
      e.total = 32'd0; e.erro = 1'b1; e.est = 1'b0; e.lat = 1;
    end else begin
      t = 64'(a) * 64'd31536000 + 64'(m) * 64'd2592000 + 64'(d) * 64'd86400 +
          64'(h) * 64'd3600 + 64'(mi) * 64'd60 + 64'(s);
      e.erro  = 1'b0;
      e.est   = (t > 64'h0000_0000_FFFF_FFFF);
      e.total = e.est ? 32'hFFFF_FFFF : t[31:0];
      e.lat   = 6;
    end
    return e;
  endfunction

  // Reference handshake: decides acceptance from the inputs alone.
  initial begin
    esp_t e;
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
        fila.delete();
        rem = 0;
      end else if (rem == 0 && inicio) begin
        e = modelo(anos, mes, dias, horas, minutos, segundos, cyc);
        fila.push_back(e);
        rem = e.lat;
      end else if (rem > 0) begin
        rem--;
      end
    end
  end

  // Scoreboard: every pronto pulse is checked against the oldest expectation.
  initial begin
    esp_t e;
    forever begin
      @(negedge clk);
      if (pronto) begin
        if (fila.size() == 0) begin
          chk("pronto_inesperado", 32'(pronto), 32'd0);
        end else begin
          e = fila.pop_front();
          chk("total_seg",  total_seg,        e.total);
          chk("erro_faixa", 32'(erro_faixa),  32'(e.erro));
          chk("estouro",    32'(estouro),     32'(e.est));
          chk("latencia",   32'(cyc - e.aceito), 32'(e.lat));
          chk("excl",       32'(ocupado),     32'd0);
        end
      end
    end
  end

  task automatic campos(input logic [31:0] a, m, d, h, mi, s);
    anos = a; mes = m; dias = d; horas = h; minutos = mi; segundos = s;
  endtask

  task automatic op(input logic [31:0] a, m, d, h, mi, s);
    int t;
    t = 0;
    @(negedge clk);
    while (rem != 0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (rem != 0) chk("timeout_idle", 32'(rem), 32'd0);
    campos(a, m, d, h, mi, s);
    inicio = 1'b1;
    @(negedge clk);
    inicio = 1'b0;
  endtask

  task automatic saidas_zero(input string tag);
    chk({tag, "_total"},   total_seg,          32'd0);
    chk({tag, "_ocupado"}, 32'(ocupado),       32'd0);
    chk({tag, "_pronto"},  32'(pronto),        32'd0);
    chk({tag, "_erro"},    32'(erro_faixa),    32'd0);
    chk({tag, "_est"},     32'(estouro),       32'd0);
  endtask

  initial begin
    int t;
    rst_n  = 1'b0;
    inicio = 1'b1;
    campos($urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
    repeat (2) @(negedge clk);
    saidas_zero("reset");

    // Release with inicio still high: accepted at the first edge out of reset.
    campos(32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6);
    rst_n = 1'b1;
    @(negedge clk);
    inicio = 1'b0;

    op(32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    op(32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6);
    op(32'd0, 32'd12, 32'd0, 32'd0, 32'd0, 32'd0);
    op(32'd0, 32'd0, 32'd0, 32'd0, 32'd60, 32'd0);
    op(32'd0, 32'd0, 32'd30, 32'd0, 32'd0, 32'd0);
    op(32'd136, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    op(32'd136, 32'd11, 32'd29, 32'd23, 32'd59, 32'd59);
    op(32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    op(32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd60);

    // inicio pulsed while busy must be ignored.
    op(32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7);
    repeat (2) @(negedge clk);
    campos(32'd9, 32'd9, 32'd9, 32'd9, 32'd9, 32'd9);
    inicio = 1'b1;
    @(negedge clk);
    inicio = 1'b0;

    // Held-high inicio: fields scrambled whenever a conversion is in flight.
    for (int i = 0; i < 20; i++) begin
      if (rem == 0) campos(32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2);
      else          campos($urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
      inicio = 1'b1;
      @(negedge clk);
    end
    inicio = 1'b0;

    // Reset landing on the edge where the FSM sits in DIAS.
    op(32'd5, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    saidas_zero("reset_meio");
    rst_n = 1'b1;
    op(32'd3, 32'd10, 32'd20, 32'd12, 32'd30, 32'd45);
    op(32'd0, 32'd11, 32'd29, 32'd23, 32'd59, 32'd59);

    t = 0;
    while ((fila.size() != 0 || rem != 0) && t < 40) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    chk("fila_vazia", 32'(fila.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
